// File: rtl/rv_ctl.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback steps and decodes the datapath strobes and mux selects per state.
module rv_ctl #(
   parameter int DPWIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DPWIDTH-1:0] instr,
   input  logic               zero,
   output logic               pcsourse,
   output logic               pcwrite,
   output logic               pccen,
   output logic               irwrite,
   output logic               regwen,
   output logic               mdrwrite,
   output logic               dmem_we,
   output logic               illegal,
   output logic [1:0]         wbsel,
   output logic [1:0]         immsel,
   output logic [1:0]         asel,
   output logic [1:0]         bsel,
   output logic [3:0]         alusel
);

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR,
      MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, HALT
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   state_t     state;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       r_legal;
   logic [3:0] r_alu;
   logic [3:0] i_alu;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign funct7       = instr[31:25];
   assign unused_instr = ^instr;

   function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Only ADD/SUB and SRL/SRA have an alternate funct7; I-type never subtracts.
   assign r_legal = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
   assign r_alu   = alu_op(funct3, funct7 == F7_ALT);
   assign i_alu   = alu_op(funct3, (funct3 == 3'b101) && instr[30]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         case (state)
            FETCH: state <= DECODE;
            DECODE: begin
               case (opcode)
                  OP_R:               state <= EXEC_R;
                  OP_I:               state <= EXEC_I;
                  OP_LOAD, OP_STORE:  state <= MEM_ADDR;
                  OP_BRANCH:          state <= BRANCH;
                  OP_JAL:             state <= JAL;
                  default:            state <= HALT;
               endcase
            end
            EXEC_R:   state <= r_legal ? ALU_WB : HALT;
            EXEC_I:   state <= ALU_WB;
            ALU_WB:   state <= FETCH;
            MEM_ADDR: begin
               if (funct3 != 3'b010)
                  state <= HALT;
               else if (opcode == OP_LOAD)
                  state <= MEM_RD;
               else
                  state <= MEM_WR;
            end
            MEM_RD:   state <= MEM_WB;
            MEM_WB:   state <= FETCH;
            MEM_WR:   state <= FETCH;
            BRANCH:   state <= ((funct3 == 3'b000) || (funct3 == 3'b001)) ? FETCH : HALT;
            JAL:      state <= FETCH;
            default:  state <= HALT;
         endcase
      end
   end

   // Outputs stay combinational: IR and the zero flag only become valid inside
   // the state that uses them, so a registered decode would act on stale data.
   always_comb begin
      pcsourse = 1'b0;
      pcwrite  = 1'b0;
      pccen    = 1'b0;
      irwrite  = 1'b0;
      regwen   = 1'b0;
      mdrwrite = 1'b0;
      dmem_we  = 1'b0;
      illegal  = 1'b0;
      wbsel    = 2'd0;
      immsel   = 2'd0;
      asel     = 2'd0;
      bsel     = 2'd0;
      alusel   = ALU_ADD;
      if (!rst) begin
         case (state)
            FETCH: begin
               irwrite = 1'b1;
               pccen   = 1'b1;
               pcwrite = 1'b1;
            end
            DECODE: begin
               asel   = 2'd1;
               immsel = (opcode == OP_JAL) ? 2'd3 : 2'd2;
            end
            EXEC_R: begin
               bsel   = 2'd1;
               alusel = r_legal ? r_alu : ALU_ADD;
            end
            EXEC_I: alusel = i_alu;
            ALU_WB: begin
               wbsel  = 2'd1;
               regwen = 1'b1;
            end
            MEM_ADDR: immsel = (opcode == OP_STORE) ? 2'd1 : 2'd0;
            MEM_RD:   mdrwrite = 1'b1;
            MEM_WB:   regwen = 1'b1;
            MEM_WR:   dmem_we = 1'b1;
            BRANCH: begin
               bsel   = 2'd1;
               alusel = ALU_SUB;
               if (((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero)) begin
                  pcwrite  = 1'b1;
                  pcsourse = 1'b1;
               end
            end
            JAL: begin
               wbsel    = 2'd2;
               regwen   = 1'b1;
               pcwrite  = 1'b1;
               pcsourse = 1'b1;
            end
            HALT:    illegal = 1'b1;
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule
